// File: rtl/matrix_display_pkg.sv
// Shared types and constants for the matrix display scanner.
// Build option: MATRIX_DISPLAY_SIGNED_EN (see matrix_display_scanner.sv).
package matrix_display_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        SCAN = 1'b1
    } disp_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_BLANK = 4'hF;

    // 10^n, used to size the displayable decimal range.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    // Index width for a dimension of n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_display_scanner_bcd.sv
// bcd_convert_n: combinational binary-to-BCD (double-dabble) with
// leading-zero blanking. The input must already be limited to the
// DIGITS-wide decimal range.
module bcd_convert_n
    import matrix_display_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int IN_W   = 10
) (
    input  logic [IN_W-1:0]     bin_in,
    output logic [DIGITS*4-1:0] bcd_out
);

    logic [DIGITS*4-1:0] raw;
    logic                seen_nz;

    // Double-dabble: before each shift, add 3 to every digit that is >= 5.
    always_comb begin
        raw = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (raw[d*4 +: 4] >= 4'd5) begin
                    raw[d*4 +: 4] = raw[d*4 +: 4] + 4'd3;
                end
            end
            raw = {raw[DIGITS*4-2:0], bin_in[i]};
        end
    end

    // Blank every digit above the most significant non-zero one; digit 0 is always shown.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        seen_nz = 1'b0;
        bcd_out = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (raw[d*4 +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            bcd_out[d*4 +: 4] = seen_nz ? raw[d*4 +: 4] : BCD_BLANK;
        end
        bcd_out[3:0] = raw[3:0];
    end

endmodule

// File: rtl/matrix_display_scanner.sv
// matrix_display_scanner: walks a ROWS x COLS result matrix one element per
// dwell period, saturates each element to DIGITS decimal digits and drives
// registered BCD digits plus row/column index to the HEX driver layer.
// Build option: define MATRIX_DISPLAY_SIGNED_EN for two's-complement
// elements and an extra 'neg' output.
module matrix_display_scanner
    import matrix_display_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ELEM_W = 32,
    parameter int DIGITS = 3,
    parameter int DWELL  = 1
) (
    input  logic                          clk_slow,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [ROWS*COLS*ELEM_W-1:0]   result_flat,
    input  logic                          mode_auto,
    input  logic                          step,
    input  logic                          hold,
    output logic [DIGITS*4-1:0]           digits_bcd,
    output logic [idx_w(ROWS)-1:0]        row_out,
    output logic [idx_w(COLS)-1:0]        col_out,
    output logic                          valid,
    output logic                          overflow,
    output logic                          scan_done
`ifdef MATRIX_DISPLAY_SIGNED_EN
    ,
    output logic                          neg
`endif
);

    localparam int              RW      = idx_w(ROWS);
    localparam int              CW      = idx_w(COLS);
    localparam int              DW      = idx_w(DWELL);
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam int              VAL_W   = $clog2(MAX_VAL + 1);
    localparam int              CMP_W   = (ELEM_W > VAL_W) ? ELEM_W : VAL_W;

    disp_state_t          state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic                 mode_q, mode_d;
    logic                 wrap_q, wrap_d;
    logic [DIGITS*4-1:0]  digits_q, digits_d;
    logic [RW-1:0]        row_out_q, row_out_d;
    logic [CW-1:0]        col_out_q, col_out_d;
    logic                 valid_q, valid_d;
    logic                 overflow_q, overflow_d;
    logic                 scan_done_q, scan_done_d;

    logic [ELEM_W-1:0]    elem;
    logic [ELEM_W-1:0]    elem_mag;
    logic                 sat_over;
    logic [VAL_W-1:0]     sat_val;
    logic [DIGITS*4-1:0]  bcd_val;
    logic                 advance;
    logic                 last_elem;

    // Select the element under the pointer.
    always_comb begin
        elem = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (row_q == RW'(r) && col_q == CW'(c)) begin
                    elem = result_flat[(r*COLS + c)*ELEM_W +: ELEM_W];
                end
            end
        end
    end

`ifdef MATRIX_DISPLAY_SIGNED_EN
    logic elem_neg;
    logic neg_q, neg_d;
    // Negation of the most negative value yields 2^(ELEM_W-1) read as unsigned, which saturates.
    assign elem_neg = elem[ELEM_W-1];
    assign elem_mag = elem_neg ? (~elem + 1'b1) : elem;
`else
    assign elem_mag = elem;
`endif

    // Compare at full width so no high bits are lost before saturating.
    assign sat_over = CMP_W'(elem_mag) > CMP_W'(MAX_VAL);
    assign sat_val  = sat_over ? VAL_W'(MAX_VAL) : VAL_W'(elem_mag);

    bcd_convert_n #(
        .DIGITS (DIGITS),
        .IN_W   (VAL_W)
    ) u_bcd (
        .bin_in  (sat_val),
        .bcd_out (bcd_val)
    );

    // Next-state, pointer stepping and output-stage values; defaults are the reset values.
    always_comb begin
        state_d     = WAIT;
        row_d       = '0;
        col_d       = '0;
        dwell_d     = '0;
        wrap_d      = 1'b0;
        digits_d    = {DIGITS{BCD_BLANK}};
        row_out_d   = '0;
        col_out_d   = '0;
        valid_d     = 1'b0;
        overflow_d  = 1'b0;
        scan_done_d = 1'b0;
`ifdef MATRIX_DISPLAY_SIGNED_EN
        neg_d       = 1'b0;
`endif
        mode_d      = mode_auto;
        last_elem   = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
        advance     = !hold && (mode_q ? (dwell_q == DW'(DWELL - 1)) : step);

        case (state_q)
            WAIT: begin
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // start falling leaves every default in place, which also drops a pending scan_done.
                if (start) begin
                    state_d     = SCAN;
                    digits_d    = bcd_val;
                    row_out_d   = row_q;
                    col_out_d   = col_q;
                    valid_d     = 1'b1;
                    overflow_d  = sat_over;
`ifdef MATRIX_DISPLAY_SIGNED_EN
                    neg_d       = elem_neg;
`endif
                    // The wrap is reported one edge later, when (0,0) reaches the outputs.
                    scan_done_d = wrap_q;
                    wrap_d      = advance && last_elem;

                    row_d = row_q;
                    col_d = col_q;
                    if (advance) begin
                        if (col_q == CW'(COLS - 1)) begin
                            col_d = '0;
                            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end

                    if (mode_auto != mode_q) begin
                        dwell_d = '0;
                    end else if (hold || !mode_q) begin
                        dwell_d = dwell_q;
                    end else if (advance) begin
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // State, pointer, dwell counter and registered outputs.
    always_ff @(posedge clk_slow or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT;
            row_q       <= '0;
            col_q       <= '0;
            dwell_q     <= '0;
            mode_q      <= 1'b0;
            wrap_q      <= 1'b0;
            digits_q    <= {DIGITS{BCD_BLANK}};
            row_out_q   <= '0;
            col_out_q   <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            mode_q      <= mode_d;
            wrap_q      <= wrap_d;
            digits_q    <= digits_d;
            row_out_q   <= row_out_d;
            col_out_q   <= col_out_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            scan_done_q <= scan_done_d;
        end
    end

`ifdef MATRIX_DISPLAY_SIGNED_EN
    // Sign flag registered alongside the digits.
    always_ff @(posedge clk_slow or negedge reset_n) begin
        if (!reset_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
    assign neg = neg_q;
`endif

    assign digits_bcd = digits_q;
    assign row_out    = row_out_q;
    assign col_out    = col_out_q;
    assign valid      = valid_q;
    assign overflow   = overflow_q;
    assign scan_done  = scan_done_q;

endmodule
